// File: rtl/mc_controller_v2.sv
// mc_controller_v2 : multi-cycle RV32I control unit for a shared-ALU,
// single-memory datapath. It decodes the latched instruction fields every
// cycle and sequences the datapath through a Moore FSM.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   op, func3, func7b5  latched instruction fields
//   zero, lt, ltu       ALU flags used for branch resolution
//   mem_ready           memory completes its access this cycle
//   immsrc              immediate format (combinational from op)
//   alusrca, alusrcb    ALU operand selects
//   resultsrc, adrsrc   result mux and memory address selects
//   alucontrol          ALU operation code (zero-extended 4-bit code)
//   irwrite, pcwrite,
//   regwrite, memwrite  datapath enables, forced low while reset is high
//   illegal             sticky illegal-instruction flag
//   retired             count of completed instructions, wraps
module mc_controller_v2 #(
    parameter int ALUCTRL_W    = 4,
    parameter int EN_MEM_READY = 1,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           func3,
    input  logic                 func7b5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic [2:0]           immsrc,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           resultsrc,
    output logic                 adrsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic                 regwrite,
    output logic                 memwrite,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
        S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic             mr_s;
    logic [1:0]       alusrca_s, alusrcb_s, resultsrc_s;
    logic             adrsrc_s, irw_s, pcupd_s, branch_s, rw_s, mw_s, retire_s;
    logic [3:0]       aluc_s;

    // ALU function decode; sub only for R-type (op[5]) with bit 30 set
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic f7, input logic is_r);
        case (f3)
            3'b000:  alu_decode = (is_r && f7) ? 4'd1 : 4'd0;
            3'b001:  alu_decode = 4'd7;
            3'b010:  alu_decode = 4'd5;
            3'b011:  alu_decode = 4'd6;
            3'b100:  alu_decode = 4'd4;
            3'b101:  alu_decode = f7 ? 4'd9 : 4'd8;
            3'b110:  alu_decode = 4'd3;
            3'b111:  alu_decode = 4'd2;
            default: alu_decode = 4'd0;
        endcase
    endfunction

    // Branch condition from the ALU flags of rs1 - rs2
    function automatic logic br_taken(input logic [2:0] f3, input logic z,
                                      input logic s_lt, input logic u_lt);
        case (f3)
            3'b000:  br_taken = z;
            3'b001:  br_taken = ~z;
            3'b100:  br_taken = s_lt;
            3'b101:  br_taken = ~s_lt;
            3'b110:  br_taken = u_lt;
            3'b111:  br_taken = ~u_lt;
            default: br_taken = 1'b0;
        endcase
    endfunction

    assign mr_s = (EN_MEM_READY != 0) ? mem_ready : 1'b1;

    // Immediate format selection straight from the opcode
    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: immsrc = 3'b000;
            OP_STORE:               immsrc = 3'b001;
            OP_BRANCH:              immsrc = 3'b010;
            OP_JAL:                 immsrc = 3'b011;
            OP_LUI, OP_AUIPC:       immsrc = 3'b100;
            default:                immsrc = 3'b000;
        endcase
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d     = state_q;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        resultsrc_s = 2'b00;
        adrsrc_s    = 1'b0;
        aluc_s      = 4'd0;
        irw_s       = 1'b0;
        pcupd_s     = 1'b0;
        branch_s    = 1'b0;
        rw_s        = 1'b0;
        mw_s        = 1'b0;
        retire_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                irw_s       = mr_s;
                pcupd_s     = mr_s;
                if (mr_s) state_d = S_DECODE;
                else      state_d = S_FETCH;
            end
            S_DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: begin
                        if (func3 == 3'b010) state_d = S_MEMADR;
                        else                 state_d = S_ILLEGAL;
                    end
                    OP_R:      state_d = S_EXECR;
                    OP_I:      state_d = S_EXECI;
                    OP_BRANCH: begin
                        if (func3[2:1] == 2'b01) state_d = S_ILLEGAL;
                        else                     state_d = S_BRANCH;
                    end
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR1;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_AUIPC;
                    default:   state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                // only load/store reach here; op[5] separates them
                if (op[5]) state_d = S_MEMWRITE;
                else       state_d = S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc_s = 1'b1;
                if (mr_s) state_d = S_MEMWB;
                else      state_d = S_MEMREAD;
            end
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                rw_s        = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc_s = 1'b1;
                mw_s     = 1'b1;
                retire_s = mr_s;
                if (mr_s) state_d = S_FETCH;
                else      state_d = S_MEMWRITE;
            end
            S_EXECR: begin
                alusrca_s = 2'b10;
                aluc_s    = alu_decode(func3, func7b5, op[5]);
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                aluc_s    = alu_decode(func3, func7b5, 1'b0);
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                rw_s     = 1'b1;
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_s = 2'b10;
                aluc_s    = 4'd1;
                branch_s  = 1'b1;
                retire_s  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b10;
                pcupd_s   = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR1: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                state_d   = S_JALR2;
            end
            S_LUI: begin
                alusrca_s = 2'b11;
                alusrcb_s = 2'b01;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    // State, sticky illegal flag and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_d == S_ILLEGAL);
            if (retire_s) retired_q <= retired_q + CNT_W'(1);
            else          retired_q <= retired_q;
        end
    end

    assign alusrca    = alusrca_s;
    assign alusrcb    = alusrcb_s;
    assign resultsrc  = resultsrc_s;
    assign adrsrc     = adrsrc_s;
    assign alucontrol = ALUCTRL_W'(aluc_s);
    // enables are gated by reset so nothing is written while it is held
    assign irwrite    = irw_s & ~reset;
    assign pcwrite    = (pcupd_s | (branch_s & br_taken(func3, zero, lt, ltu))) & ~reset;
    assign regwrite   = rw_s & ~reset;
    assign memwrite   = mw_s & ~reset;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_controller_v2.sv
// Self-checking bench for mc_controller_v2: directed scenarios followed by
// randomized instructions, each compared cycle by cycle against an
// instruction-level model of the expected control outputs.
module tb_mc_controller_v2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  op = 7'd0;
    logic [2:0]  func3 = 3'd0;
    logic        func7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic        mem_ready = 1'b1;
    logic [2:0]  immsrc;
    logic [1:0]  alusrca, alusrcb, resultsrc;
    logic        adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal;
    logic [3:0]  alucontrol;
    logic [31:0] retired;

    mc_controller_v2 dut (
        .clk(clk), .reset(reset), .op(op), .func3(func3), .func7b5(func7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .resultsrc(resultsrc), .adrsrc(adrsrc), .alucontrol(alucontrol),
        .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
        .memwrite(memwrite), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic [15:0] v;
    } cyc_t;

    cyc_t        exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] exp_ret = 32'd0;
    logic [15:0] obs_s;

    assign obs_s = {alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                    irwrite, pcwrite, regwrite, memwrite, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pk(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] r, input logic adr,
                                       input logic [3:0] alu, input logic irw,
                                       input logic pcw, input logic rw,
                                       input logic mw, input logic ill);
        return {a, b, r, adr, alu, irw, pcw, rw, mw, ill};
    endfunction

    task automatic push(input logic mr, input logic [15:0] v);
        cyc_t c;
        c.mr = mr;
        c.v  = v;
        exp_q.push_back(c);
    endtask

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (f3 == 3'd0 && is_r && f7) return 4'd1;
        if (f3 == 3'd5 && f7) return 4'd9;
        return tbl[f3];
    endfunction

    function automatic logic [2:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0000011 || o == 7'b0010011 || o == 7'b1100111) return 3'b000;
        if (o == 7'b0100011) return 3'b001;
        if (o == 7'b1100011) return 3'b010;
        if (o == 7'b1101111) return 3'b011;
        if (o == 7'b0110111 || o == 7'b0010111) return 3'b100;
        return 3'b000;
    endfunction

    // Expected per-cycle outputs of one whole instruction
    task automatic gen(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic l, input logic lu,
                       input int fw, input int mwt, output bit ret);
        logic [15:0] wb;
        logic        tk;
        wb  = pk(2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ret = 1'b1;
        for (int i = 0; i < fw; i++) push(1'b0, pk(2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push(1'b1, pk(2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        push(1'($urandom), pk(2'd1, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (o == 7'b0000011 && f3 == 3'd2) begin
            push(1'($urandom), pk(2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < mwt; i++) push(1'b0, pk(2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            push(1'b1, pk(2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            push(1'($urandom), pk(2'd0, 2'd0, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        end else if (o == 7'b0100011 && f3 == 3'd2) begin
            push(1'($urandom), pk(2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < mwt; i++) push(1'b0, pk(2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            push(1'b1, pk(2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end else if (o == 7'b0110011) begin
            push(1'($urandom), pk(2'd2, 2'd0, 2'd0, 1'b0, alu_ref(f3, f7, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            push(1'($urandom), wb);
        end else if (o == 7'b0010011) begin
            push(1'($urandom), pk(2'd2, 2'd1, 2'd0, 1'b0, alu_ref(f3, f7, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            push(1'($urandom), wb);
        end else if (o == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin
            case (f3)
                3'd0:    tk = z;
                3'd1:    tk = !z;
                3'd4:    tk = l;
                3'd5:    tk = !l;
                3'd6:    tk = lu;
                default: tk = !lu;
            endcase
            push(1'($urandom), pk(2'd2, 2'd0, 2'd0, 1'b0, 4'd1, 1'b0, tk, 1'b0, 1'b0, 1'b0));
        end else if (o == 7'b1101111) begin
            push(1'($urandom), pk(2'd1, 2'd2, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            push(1'($urandom), wb);
        end else if (o == 7'b1100111) begin
            push(1'($urandom), pk(2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            push(1'($urandom), pk(2'd1, 2'd2, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            push(1'($urandom), wb);
        end else if (o == 7'b0110111) begin
            push(1'($urandom), pk(2'd3, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            push(1'($urandom), wb);
        end else if (o == 7'b0010111) begin
            push(1'($urandom), pk(2'd1, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            push(1'($urandom), wb);
        end else begin
            ret = 1'b0;
            for (int i = 0; i < 10; i++) push(1'($urandom), pk(2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    // Play up to n expected cycles (all when n < 0), then drop the rest
    task automatic run_q(input int n);
        cyc_t c;
        int   k;
        k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            c = exp_q.pop_front();
            mem_ready = c.mr;
            @(negedge clk);
            check("cycle_outputs", 32'(obs_s), 32'(c.v));
            @(posedge clk);
            #1;
            k++;
        end
        exp_q.delete();
    endtask

    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input logic l, input logic lu,
                            input int fw, input int mwt);
        bit ret;
        op = o; func3 = f3; func7b5 = f7; zero = z; lt = l; ltu = lu;
        gen(o, f3, f7, z, l, lu, fw, mwt, ret);
        #1;
        check("immsrc", 32'(immsrc), 32'(imm_ref(o)));
        run_q(-1);
        if (ret) exp_ret = exp_ret + 32'd1;
        check("retired", retired, exp_ret);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            check("reset_enables", 32'({irwrite, pcwrite, regwrite, memwrite}), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        exp_ret = 32'd0;
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_retired", retired, 32'd0);
    endtask

    initial begin
        bit          ret;
        int          k;
        logic [6:0]  o;
        logic [2:0]  f3;
        logic [6:0]  ops [9];
        logic [2:0]  bf3 [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        do_reset(2);
        // sub, lw with three memory wait cycles
        do_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        do_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
        // branch sweep: bne nz, bne z, bgeu ltu, blt lt
        do_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        do_instr(7'b1100011, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        do_instr(7'b1100011, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        do_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        do_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        do_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        do_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
        // unknown opcode traps; reset clears it
        do_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_reset(1);
        // load with bad width, branch with reserved funct3
        do_instr(7'b0000011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_reset(1);
        do_instr(7'b1100011, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_reset(1);
        do_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // sw stalled in MEMWRITE; reset arrives in the second wait cycle
        op = 7'b0100011; func3 = 3'd2; func7b5 = 1'b0;
        gen(op, func3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5, ret);
        run_q(4);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_reset_memwrite", 32'(memwrite), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = 32'd0;
        check("sw_reset_retired", retired, 32'd0);
        do_instr(7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // random legal instructions with random wait states and flags
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 8);
            o  = ops[k];
            f3 = 3'($urandom);
            if (k <= 1) f3 = 3'd2;
            if (k == 4) f3 = bf3[$urandom_range(0, 5)];
            do_instr(o, f3, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
Next-generation multi-cycle RV32I control unit. It drives the same shared-ALU, single-memory datapath as the current controller and adds the following:
- full branch set, jalr, lui and auipc;
- a memory ready handshake with wait states;
- a 4+ bit ALU control code;
- illegal-instruction trapping;
- a retired-instruction counter.

It sits beside the datapath and decodes the latched instruction fields each cycle.

Parameters:
ALUCTRL_W, 4, alucontrol width; must be >=4; codes are zero-extended.
EN_MEM_READY, 1, 1 = honour mem_ready; 0 = mem_ready is internally tied to 1.
CNT_W, 32, width of the retired counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
op  in  7  instruction opcode
func3  in  3  instruction funct3
func7b5  in  1  instruction bit 30
zero  in  1  ALU result == 0
lt  in  1  ALU signed SrcA<SrcB
ltu  in  1  ALU unsigned SrcA<SrcB
mem_ready  in  1  memory completes access this cycle
immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op; 000 for unknown op)
alusrca  out  2  00 PC, 01 OldPC, 10 A(rs1), 11 zero
alusrcb  out  2  00 WriteData(rs2), 01 ImmExt, 10 const 4
resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
adrsrc  out  1  0 PC, 1 Result
alucontrol  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
irwrite  out  1  instruction register enable
pcwrite  out  1  PC enable
regwrite  out  1  register file write
memwrite  out  1  memory write
illegal  out  1  sticky illegal-instruction flag
retired  out  CNT_W  instructions completed, wraps

Behaviour:
- Moore FSM. State register and counter update on posedge clk.
- pcwrite = pcupdate | (branch & taken), combinational.
- Default output values: alusrca = alusrcb = resultsrc = 00, adrsrc = 0, alucontrol = add, all enables 0.

Reset:
- While reset = 1, irwrite, pcwrite, regwrite and memwrite are forced to 0 combinationally, including mid-operation.
- At the next edge: state = FETCH, illegal = 0, retired = 0.

States, with non-default outputs and transitions (mem_ready read as 1 when EN_MEM_READY = 0):
- FETCH: alusrcb=10, resultsrc=10, irwrite=pcupdate=mem_ready. Go to DECODE if mem_ready, else stay.
- DECODE: alusrca=01, alusrcb=01. Next state by op:
  - 0000011 -> MEMADR, 0100011 -> MEMADR
  - 0110011 -> EXECR, 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL, 1100111 -> JALR1
  - 0110111 -> LUI, 0010111 -> AUIPC
  - any other op -> ILLEGAL
  - Also -> ILLEGAL: load/store with func3 != 010; branch with func3 010 or 011.
- MEMADR: alusrca=10, alusrcb=01. Next: MEMREAD for load, MEMWRITE for store.
- MEMREAD: adrsrc=1. Stay until mem_ready, then MEMWB.
- MEMWB: resultsrc=01, regwrite=1. -> FETCH.
- MEMWRITE: adrsrc=1, memwrite=1, held every cycle until mem_ready. -> FETCH.
- EXECR: alusrca=10, alusrcb=00, function decode. -> ALUWB.
- EXECI: alusrca=10, alusrcb=01, function decode with func7b5 ignored except for func3 101. -> ALUWB.
- ALUWB: regwrite=1. -> FETCH.
- BRANCH: alusrca=10, alusrcb=00, sub, branch=1. -> FETCH.
  - taken by func3: 000 zero, 001 ~zero, 100 lt, 101 ~lt, 110 ltu, 111 ~ltu.
- JAL: alusrca=01, alusrcb=10, pcupdate=1. -> ALUWB.
- JALR1: alusrca=10, alusrcb=01, add. -> JALR2.
- JALR2: alusrca=01, alusrcb=10, pcupdate=1. PC <- ALUOut; the datapath clears bit 0. -> ALUWB.
- LUI: alusrca=11, alusrcb=01. -> ALUWB.
- AUIPC: alusrca=01, alusrcb=01. -> ALUWB.
- ILLEGAL: illegal=1, all enables 0. Absorbing until reset.

Function decode (func3 -> alucontrol):
- 000: add, or sub when op[5] & func7b5 (R-type only)
- 001: sll
- 010: slt
- 011: sltu
- 100: xor
- 101: srl, or sra when func7b5
- 110: or
- 111: and

Retired counter:
- Increments by 1 on every edge that leaves MEMWB, MEMWRITE (with mem_ready), ALUWB or BRANCH.
- Never increments in ILLEGAL.

Latency with mem_ready = 1:
- R/I/lui/auipc: 4 cycles
- load: 5; store: 4
- branch: 3
- jal: 4; jalr: 5

Each wait cycle (mem_ready = 0 in FETCH, MEMREAD or MEMWRITE) adds exactly 1 cycle.

Test Plan:
- Reset 2 cycles, then sub (op=0110011, func3=000, func7b5=1), mem_ready=1.
  -> States FETCH, DECODE, EXECR, ALUWB. alucontrol=0001 in EXECR. regwrite=1 only in ALUWB. retired 0->1.
- lw with mem_ready=0 for 3 cycles in MEMREAD.
  -> adrsrc=1 for 4 cycles. MEMWB has resultsrc=01, regwrite=1. Total 8 cycles.
- Branch sweep:
  - bne with zero=0 -> pcwrite=1 in BRANCH.
  - bne with zero=1 -> pcwrite=0.
  - bgeu with ltu=1 -> pcwrite=0.
  - blt with lt=1 -> pcwrite=1.
  - alucontrol=0001 in each case.
- jalr -> FETCH, DECODE, JALR1, JALR2, ALUWB. pcwrite=1 only in FETCH and JALR2. immsrc=000.
- lui -> alusrca=11, immsrc=100. op=0000000 -> ILLEGAL after DECODE, illegal=1, zero writes for 10 cycles, retired unchanged. Reset clears illegal.
- sw with mem_ready held 0 in MEMWRITE, reset asserted in the 2nd wait cycle.
  -> memwrite=0 in that same cycle. After reset releases, state is FETCH and retired=0.
